// File: rtl/seg_scan_decoder.sv
// Receive side of a multiplexed 4-digit seven-segment bus: synchronizes the
// active-low anode/segment lines, waits for them to settle, decodes each
// digit back to BCD and publishes complete 4-digit frames with sticky errors.
module seg_scan_decoder #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  input  logic [3:0] an_in,
  input  logic       err_clr,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic [3:0] dig3,
  output logic [3:0] blank,
  output logic       frame_valid,
  output logic [1:0] err_flags
);

  localparam int CW = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ACC = CW'(SETTLE_CYCLES - 2);

  logic [10:0]         meta_q, sync_q, prev_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                accept;
  logic [3:0]          an_s;
  logic [6:0]          seg_s;
  logic [3:0]          dec_dig;
  logic                dec_blank, dec_bad;
  logic [3:0]          slot_oh;
  logic                an_multi, cap_en, frame_done;
  logic [3:0][3:0]     cap_dig_q, dig_q;
  logic [3:0]          cap_blank_q, blank_q, seen_q, seen_d;
  logic                fv_q;
  logic [1:0]          err_q, err_d;

  assign {an_s, seg_s} = sync_q;

  // Synchronizer and stability history. Reset loads the idle bus value
  // (all lines high) so a cleared pipeline never looks like a multi-anode scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '1;
      sync_q <= '1;
      prev_q <= '1;
      cnt_q  <= '0;
    end else begin
      meta_q <= {an_in, seg_in};
      sync_q <= meta_q;
      prev_q <= sync_q;
      cnt_q  <= cnt_d;
    end
  end

  // Settle counter: restarts on any change, saturates so a held value fires once.
  always_comb begin
    cnt_d = cnt_q;
    if (sync_q != prev_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // cnt_q counts repeats beyond the first two cycles of the current value.
  assign accept = (sync_q == prev_q) && (cnt_q == CNT_ACC);

  // Active-low segment pattern (g..a) to BCD digit.
  always_comb begin
    dec_dig   = 4'hE;
    dec_blank = 1'b0;
    dec_bad   = 1'b0;
    case (seg_s)
      7'b1000000: dec_dig = 4'd0;
      7'b1111001: dec_dig = 4'd1;
      7'b0100100: dec_dig = 4'd2;
      7'b0110000: dec_dig = 4'd3;
      7'b0011001: dec_dig = 4'd4;
      7'b0010010: dec_dig = 4'd5;
      7'b0000010: dec_dig = 4'd6;
      7'b1111000: dec_dig = 4'd7;
      7'b0000000: dec_dig = 4'd8;
      7'b0010000: dec_dig = 4'd9;
      7'b1111111: begin
        dec_dig   = 4'hF;
        dec_blank = 1'b1;
      end
      default:    dec_bad = 1'b1;
    endcase
  end

  // Anode classification: idle, single digit slot, or several anodes at once.
  always_comb begin
    slot_oh  = 4'b0000;
    an_multi = 1'b0;
    case (an_s)
      4'b1111: begin
      end
      4'b1110, 4'b1101, 4'b1011, 4'b0111: slot_oh = ~an_s;
      default: an_multi = 1'b1;
    endcase
  end

  assign cap_en     = accept && (slot_oh != 4'b0000);
  assign frame_done = (seen_q == 4'b1111);

  // Seen mask restarts on frame completion; a same-cycle capture opens the next frame.
  always_comb begin
    seen_d = frame_done ? 4'b0000 : seen_q;
    if (cap_en) seen_d = seen_d | slot_oh;
    err_d = err_clr ? 2'b00 : err_q;
    err_d = err_d | {accept & an_multi, cap_en & dec_bad};
  end

  // Per-slot capture registers; latest accept for a slot wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_dig_q   <= '0;
      cap_blank_q <= '0;
      seen_q      <= '0;
    end else begin
      seen_q <= seen_d;
      for (int k = 0; k < 4; k++) begin
        if (cap_en && slot_oh[k]) begin
          cap_dig_q[k]   <= dec_dig;
          cap_blank_q[k] <= dec_blank;
        end
      end
    end
  end

  // Published frame, completion pulse and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_q   <= '0;
      blank_q <= 4'b1111;
      fv_q    <= 1'b0;
      err_q   <= 2'b00;
    end else begin
      fv_q  <= frame_done;
      err_q <= err_d;
      if (frame_done) begin
        dig_q   <= cap_dig_q;
        blank_q <= cap_blank_q;
      end
    end
  end

  assign dig0        = dig_q[0];
  assign dig1        = dig_q[1];
  assign dig2        = dig_q[2];
  assign dig3        = dig_q[3];
  assign blank       = blank_q;
  assign frame_valid = fv_q;
  assign err_flags   = err_q;

endmodule
